// File: rtl/noc_vc_credit_controller.sv
// noc_vc_credit_controller: per-VC downstream credit counters driving vc_available for VC arbitration
// Ports: clk, rst_n (async, active low); i_clear reloads all counters to BUFFER_DEPTH;
//   i_flit_valid/i_flit_vc (one-hot) consume a credit; i_credit_return[i] returns one credit to VC i;
//   o_vc_available[i] = VC i has a credit; o_credit_count packs counters (VC i at [i*COUNT_WIDTH +: COUNT_WIDTH]);
//   o_all_credits_home = every counter at BUFFER_DEPTH.
// Optional macro NOC_CREDIT_CHECK_EN adds the sticky o_credit_error flag for protocol violations.
package noc_pkg;
  typedef struct packed {
    int unsigned virtual_channels;
  } noc_config;
  localparam noc_config NOC_DEFAULT_CONFIG = '{virtual_channels: 2};
endpackage

module noc_vc_credit_controller
  import noc_pkg::*;
#(
  parameter noc_config CONFIG = NOC_DEFAULT_CONFIG,
  parameter int BUFFER_DEPTH = 8,
  localparam int CHANNELS = int'(CONFIG.virtual_channels),
  localparam int COUNT_WIDTH = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_clear,
  input  logic                            i_flit_valid,
  input  logic [CHANNELS-1:0]             i_flit_vc,
  input  logic [CHANNELS-1:0]             i_credit_return,
  output logic [CHANNELS-1:0]             o_vc_available,
  output logic [CHANNELS*COUNT_WIDTH-1:0] o_credit_count,
`ifdef NOC_CREDIT_CHECK_EN
  output logic                            o_credit_error,
`endif
  output logic                            o_all_credits_home
);
  localparam logic [COUNT_WIDTH-1:0] FULL = COUNT_WIDTH'(BUFFER_DEPTH);
  logic [CHANNELS-1:0] consume;
  logic [CHANNELS-1:0] home;
  logic [CHANNELS-1:0] viol;
  assign consume = i_flit_vc & {CHANNELS{i_flit_valid}};
  assign o_all_credits_home = &home;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_vc
    logic [COUNT_WIDTH-1:0] cnt;
    logic [COUNT_WIDTH-1:0] nxt;
    logic empty;
    logic full;
    assign empty = cnt == '0;
    assign full = cnt == FULL;
    // Saturate at both ends; a paired consume+return is a no-op.
    always_comb begin
      nxt = (consume[i] && !i_credit_return[i] && !empty) ? cnt - COUNT_WIDTH'(1) :
            (i_credit_return[i] && !consume[i] && !full) ? cnt + COUNT_WIDTH'(1) : cnt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= FULL;
      else cnt <= i_clear ? FULL : nxt;
    end
    assign viol[i] = (consume[i] && empty && !i_credit_return[i]) ||
                     (i_credit_return[i] && full && !consume[i]);
    assign home[i] = full;
    assign o_vc_available[i] = !empty;
    assign o_credit_count[i*COUNT_WIDTH +: COUNT_WIDTH] = cnt;
  end
`ifdef NOC_CREDIT_CHECK_EN
  logic not_onehot;
  assign not_onehot = i_flit_valid &&
                      ((i_flit_vc == '0) || ((i_flit_vc & (i_flit_vc - CHANNELS'(1))) != '0));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_credit_error <= 1'b0;
    else if (i_clear) o_credit_error <= 1'b0;
    else if ((|viol) || not_onehot) o_credit_error <= 1'b1;
  end
`else
  logic unused_viol;
  assign unused_viol = |viol;
`endif
endmodule
